pc_redirect_unit: RTL
=====================

# pc_redirect_unit

Program-counter next-value unit for the fetch stage: holds the architectural PC register and selects each cycle between sequential increment and one of NUM_SRC prioritised redirect requests (branch, jump, exception, …). It absorbs redirects that arrive while fetch is stalled, replays them when the stall releases, and emits a one-cycle flush pulse to the IF/ID pipeline register whenever the PC is loaded from a redirect.

## Interface
- PC_WIDTH, 16, width of PC and redirect targets
- NUM_SRC, 3, number of redirect sources; index 0 has the highest priority
- RESET_PC, 0, PC value after reset
- PC_STEP, 1, sequential increment per instruction
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hold PC (fetch stall from hazard unit)
- redirect_valid_i  in  NUM_SRC  per-source redirect request, single-cycle pulse
- redirect_target_i  in  NUM_SRC*PC_WIDTH  target of source k at bits [k*PC_WIDTH +: PC_WIDTH]
- pc_o  out  PC_WIDTH  current PC (registered)
- pc_add_o  out  PC_WIDTH  pc_o + PC_STEP, combinational, mod 2^PC_WIDTH
- flush_o  out  1  registered; high for one cycle after a redirect load
- pending_o  out  1  a redirect is held waiting for stall release
- redirect_src_o  out  clog2(NUM_SRC) (min 1)  source index of the last redirect loaded

## Operation
- Live winner: lowest index k with redirect_valid_i[k]=1; none → no live redirect.
- States: RUN (no pending), HOLD (pending redirect captured).
- RUN, stall_i=0: live winner → pc_o <= its target, flush_o <= 1, redirect_src_o <= k; else pc_o <= pc_add_o.
- RUN, stall_i=1: pc_o held; live winner → capture (target, k) into pending regs, go HOLD, pending_o=1.
- HOLD, stall_i=1: pc_o held; live winner with index < pending index overwrites pending; equal or greater index is dropped.
- HOLD, stall_i=0: load from pending unless a live redirect with index ≤ pending index exists, in which case the live one loads; flush_o <= 1; go RUN; pending cleared.
- Only one PC load per cycle; flush_o never asserts for sequential increment.
- pc_add_o wraps: 0xFFFF + 1 → 0x0000 at PC_WIDTH=16; no overflow flag.
- Redirect targets are used unmodified (no alignment masking).

## Timing
- Reset (rst=1 at an edge): pc_o=RESET_PC, flush_o=0, pending_o=0, redirect_src_o=0, state RUN; rst overrides stall and redirects in the same cycle; pending redirect discarded on reset mid-HOLD.
- Redirect in cycle n with no stall: pc_o = target from cycle n+1; flush_o high exactly in cycle n+1.
- Redirect during stall: pc_o unchanged until first cycle with stall_i=0 (cycle m); pc_o = target and flush_o=1 in cycle m+1.
- pending_o is registered; high from the cycle after capture until the cycle after release.
- Back-to-back redirects in cycles n, n+1 (no stall): both loaded; flush_o high in n+1 and n+2.

## Structure
- Shared define.v: PC_BUS derived from PC_WIDTH, PC_JUMP_ENABLE / PC_JUMP_DISABLE, RESET_PC default, state encodings RUN/HOLD.
- Sub-module pc_redirect_arb: combinational fixed-priority encoder → {any_valid, win_idx, win_target}; instantiated once.
- PC register, pending regs and FSM in top module; no other hierarchy.

## Test plan
- Reset then 4 free-run cycles, no stall → pc_o = 0,1,2,3; flush_o=0 throughout.
- pc_o=0x0010, redirect_valid_i=3'b110 (src1→0x0100, src2→0x0200) one cycle → next pc_o=0x0100, redirect_src_o=1, flush_o single-cycle pulse.
- stall_i=1 for 3 cycles; src2→0x0300 in cycle 1, src0→0x0040 in cycle 2, src1→0x0500 in cycle 3 → pending_o=1, pc_o held, after release pc_o=0x0040, src=0, one flush pulse.
- HOLD with pending src1→0x0500, release cycle carries live src0→0x0060 → pc_o=0x0060; live src2 instead → pc_o=0x0500.
- pc_o=0xFFFF, no stall → pc_add_o=0x0000, next pc_o=0x0000, flush_o=0.
- rst asserted during HOLD with pending 0x0700 → pc_o=RESET_PC, pending_o=0, flush_o=0; after rst drops, no replay of 0x0700.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and defaults for the fetch-stage PC redirect unit.
// Imported by the arbiter and the top-level PC register.
package pc_redirect_unit_pkg;

  localparam int PC_WIDTH_DEF = 16;
  localparam int NUM_SRC_DEF  = 3;
  localparam int PC_STEP_DEF  = 1;

  localparam logic PC_JUMP_ENABLE  = 1'b1;
  localparam logic PC_JUMP_DISABLE = 1'b0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int src_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect arbiter: lowest source index wins.
// Purely combinational; returns the winner's index and target.
module pc_redirect_arb
  import pc_redirect_unit_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int NUM_SRC  = NUM_SRC_DEF,
  parameter int SRC_W    = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]          valid_i,
  input  logic [NUM_SRC*PC_WIDTH-1:0] target_i,
  output logic                        any_valid_o,
  output logic [SRC_W-1:0]            win_idx_o,
  output logic [PC_WIDTH-1:0]         win_target_o
);

  // Scan from lowest priority upward so the lowest index is the last write.
  always_comb begin
    any_valid_o  = 1'b0;
    win_idx_o    = '0;
    win_target_o = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (valid_i[k]) begin
        any_valid_o  = 1'b1;
        win_idx_o    = SRC_W'(k);
        win_target_o = target_i[k*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Architectural PC register with prioritised redirects.
// Redirects seen during a stall are parked and replayed on release.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int                 PC_WIDTH = PC_WIDTH_DEF,
  parameter int                 NUM_SRC  = NUM_SRC_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                 PC_STEP  = PC_STEP_DEF,
  parameter int                 SRC_W    = src_w(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic [NUM_SRC-1:0]          redirect_valid_i,
  input  logic [NUM_SRC*PC_WIDTH-1:0] redirect_target_i,
  output logic [PC_WIDTH-1:0]         pc_o,
  output logic [PC_WIDTH-1:0]         pc_add_o,
  output logic                        flush_o,
  output logic                        pending_o,
  output logic [SRC_W-1:0]            redirect_src_o
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q, flush_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [SRC_W-1:0]    pend_idx_q, pend_idx_d;

  logic                live_v;
  logic [SRC_W-1:0]    live_idx;
  logic [PC_WIDTH-1:0] live_tgt;
  logic [PC_WIDTH-1:0] pc_add;
  logic                jump;

  assign pc_add = pc_q + PC_WIDTH'(PC_STEP);

  pc_redirect_arb #(
    .PC_WIDTH (PC_WIDTH),
    .NUM_SRC  (NUM_SRC),
    .SRC_W    (SRC_W)
  ) u_arb (
    .valid_i      (redirect_valid_i),
    .target_i     (redirect_target_i),
    .any_valid_o  (live_v),
    .win_idx_o    (live_idx),
    .win_target_o (live_tgt)
  );

  // State, PC and pending registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      src_q      <= '0;
      pend_tgt_q <= '0;
      pend_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      src_q      <= src_d;
      pend_tgt_q <= pend_tgt_d;
      pend_idx_q <= pend_idx_d;
    end
  end

  // Next state: park on a stalled redirect, leave once the stall drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (stall_i && live_v) state_d = ST_HOLD;
      ST_HOLD: if (!stall_i)          state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Datapath: pick at most one PC load source per cycle.
  always_comb begin
    pc_d       = pc_q;
    flush_d    = 1'b0;
    src_d      = src_q;
    pend_tgt_d = pend_tgt_q;
    pend_idx_d = pend_idx_q;
    jump       = PC_JUMP_DISABLE;
    unique case (state_q)
      ST_RUN: begin
        if (!stall_i) begin
          if (live_v) begin
            jump  = PC_JUMP_ENABLE;
            pc_d  = live_tgt;
            src_d = live_idx;
          end else begin
            pc_d = pc_add;
          end
        end else if (live_v) begin
          pend_tgt_d = live_tgt;
          pend_idx_d = live_idx;
        end
      end
      ST_HOLD: begin
        if (stall_i) begin
          if (live_v && (live_idx < pend_idx_q)) begin
            pend_tgt_d = live_tgt;
            pend_idx_d = live_idx;
          end
        end else begin
          jump = PC_JUMP_ENABLE;
          if (live_v && (live_idx <= pend_idx_q)) begin
            pc_d  = live_tgt;
            src_d = live_idx;
          end else begin
            pc_d  = pend_tgt_q;
            src_d = pend_idx_q;
          end
          pend_tgt_d = '0;
          pend_idx_d = '0;
        end
      end
      default: ;
    endcase
    flush_d = jump;
  end

  // Outputs: all registered except the sequential adder.
  always_comb begin
    pc_o           = pc_q;
    pc_add_o       = pc_add;
    flush_o        = flush_q;
    pending_o      = (state_q == ST_HOLD);
    redirect_src_o = src_q;
  end

endmodule
